axi4_lite_slave_ram: RTL

AXI4-Lite slave (responder) backed by a word-organised on-chip RAM with byte-strobe writes, the memory-side end of the `axi4_lite_if` slave modport. It serves frontend masters as a 4 KB scratch/data memory. Write and read channels run independent FSMs, so one read and one write can be in flight at the same time. Addresses beyond the array get SLVERR.

---
 rtl/axi4_types.sv | 19 +
 rtl/byte_en_ram.sv | 43 ++++
 rtl/axi4_lite_slave_ram.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/axi4_types.sv
// Shared AXI4-Lite types: response codes and the channel FSM state encodings.
package axi4_types;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/byte_en_ram.sv
// Word-organised RAM with one byte-enabled write port and one synchronous read port.
// A same-cycle read and write to one word returns the old contents.
module byte_en_ram #(
  parameter  int MEM_WORDS = 1024,
  parameter  int DATA_SIZE = 32,
  localparam int STRB_SIZE = DATA_SIZE / 8,
  localparam int AW        = $clog2(MEM_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        wr_addr,
  input  logic [STRB_SIZE-1:0] be,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic                 rd_zero,
  input  logic [AW-1:0]        rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] mem [MEM_WORDS];

  // Storage update; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_SIZE; b++) begin
        if (be[b]) begin
          mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read register holds its value until the next read so the response stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= {DATA_SIZE{1'b0}};
    end else if (rd_en) begin
      rd_data <= rd_zero ? {DATA_SIZE{1'b0}} : mem[rd_addr];
    end
  end

endmodule

// File: rtl/axi4_lite_slave_ram.sv
// AXI4-Lite slave backed by byte_en_ram; independent write and read channel FSMs.
// Accesses whose word index falls beyond the array complete with SLVERR.
module axi4_lite_slave_ram
  import axi4_types::*;
#(
  parameter  int ADDR_SIZE = 24,
  parameter  int DATA_SIZE = 32,
  parameter  int MEM_WORDS = 1024,
  localparam int STRB_SIZE = DATA_SIZE / 8
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [ADDR_SIZE-1:0] awaddr,
  input  logic [2:0]           awprot,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [STRB_SIZE-1:0] wstrb,
  output logic                 bvalid,
  input  logic                 bready,
  output logic [1:0]           bresp,
  input  logic                 arvalid,
  output logic                 arready,
  input  logic [ADDR_SIZE-1:0] araddr,
  input  logic [2:0]           arprot,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [DATA_SIZE-1:0] rdata,
  output logic [1:0]           rresp
);

  localparam int OFF_W  = $clog2(STRB_SIZE);
  localparam int IDX_W  = ADDR_SIZE - OFF_W;
  localparam int MEM_AW = $clog2(MEM_WORDS);

  function automatic logic addr_ok(input logic [ADDR_SIZE-1:0] a);
    logic [IDX_W-1:0] idx;
    idx = a[ADDR_SIZE-1:OFF_W];
    return (idx >> MEM_AW) == {IDX_W{1'b0}};
  endfunction

  function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_SIZE-1:0] a);
    return a[OFF_W +: MEM_AW];
  endfunction

  wr_state_t            w_state_r;
  rd_state_t            r_state_r;
  logic                 aw_held_r, w_held_r, aw_ok_r;
  logic [MEM_AW-1:0]    aw_idx_r;
  logic [DATA_SIZE-1:0] wdata_r;
  logic [STRB_SIZE-1:0] wstrb_r;
  logic                 awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
  axi_resp_t            bresp_r, rresp_r;

  logic                 aw_hs_s, w_hs_s, ar_hs_s, commit_s, wr_ok_s, ram_we_s;
  logic [MEM_AW-1:0]    wr_idx_s;
  logic [DATA_SIZE-1:0] wr_data_s;
  logic [STRB_SIZE-1:0] wr_strb_s;
  logic                 unused_s;

  assign unused_s = ^{awprot, arprot, awaddr[OFF_W-1:0], araddr[OFF_W-1:0]};

  // Handshakes and the write payload, taken from the holding registers or straight from the bus.
  always_comb begin
    aw_hs_s = awvalid & awready_r;
    w_hs_s  = wvalid & wready_r;
    ar_hs_s = arvalid & arready_r;
    if (aw_held_r) begin
      wr_idx_s = aw_idx_r;
      wr_ok_s  = aw_ok_r;
    end else begin
      wr_idx_s = word_idx(awaddr);
      wr_ok_s  = addr_ok(awaddr);
    end
    if (w_held_r) begin
      wr_data_s = wdata_r;
      wr_strb_s = wstrb_r;
    end else begin
      wr_data_s = wdata;
      wr_strb_s = wstrb;
    end
    commit_s = (w_state_r == W_IDLE) & (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);
    ram_we_s = commit_s & wr_ok_s;
  end

  // Write channel FSM: gather AW and W in any order, commit, then hold B until accepted.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_r <= W_IDLE;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      aw_ok_r   <= 1'b0;
      aw_idx_r  <= {MEM_AW{1'b0}};
      wdata_r   <= {DATA_SIZE{1'b0}};
      wstrb_r   <= {STRB_SIZE{1'b0}};
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= AXI_OKAY;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (aw_hs_s) begin
            aw_held_r <= 1'b1;
            aw_idx_r  <= word_idx(awaddr);
            aw_ok_r   <= addr_ok(awaddr);
          end
          if (w_hs_s) begin
            w_held_r <= 1'b1;
            wdata_r  <= wdata;
            wstrb_r  <= wstrb;
          end
          if (commit_s) begin
            w_state_r <= W_RESP;
            bvalid_r  <= 1'b1;
            bresp_r   <= wr_ok_s ? AXI_OKAY : AXI_SLVERR;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
          end else begin
            awready_r <= ~(aw_held_r | aw_hs_s);
            wready_r  <= ~(w_held_r | w_hs_s);
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state_r <= W_IDLE;
            bvalid_r  <= 1'b0;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          bvalid_r  <= 1'b0;
          aw_held_r <= 1'b0;
          w_held_r  <= 1'b0;
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read channel FSM: the RAM read register supplies rdata one cycle after AR.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rresp_r   <= AXI_OKAY;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (ar_hs_s) begin
            r_state_r <= R_DATA;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            rresp_r   <= addr_ok(araddr) ? AXI_OKAY : AXI_SLVERR;
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            r_state_r <= R_IDLE;
            rvalid_r  <= 1'b0;
            arready_r <= 1'b1;
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          rvalid_r  <= 1'b0;
          arready_r <= 1'b0;
        end
      endcase
    end
  end

  byte_en_ram #(
    .MEM_WORDS (MEM_WORDS),
    .DATA_SIZE (DATA_SIZE)
  ) u_ram (
    .clk     (ACLK),
    .rst     (ARESET),
    .we      (ram_we_s),
    .wr_addr (wr_idx_s),
    .be      (wr_strb_s),
    .wr_data (wr_data_s),
    .rd_en   (ar_hs_s),
    .rd_zero (~addr_ok(araddr)),
    .rd_addr (word_idx(araddr)),
    .rd_data (rdata)
  );

  assign awready = awready_r;
  assign wready  = wready_r;
  assign bvalid  = bvalid_r;
  assign bresp   = bresp_r;
  assign arready = arready_r;
  assign rvalid  = rvalid_r;
  assign rresp   = rresp_r;

endmodule
